// File: rtl/interface_out.sv
// interface_out: packs a row-major stream of 8-bit result elements into 16-bit
// memory words (first element of each pair in the low byte) and writes them
// to consecutive addresses starting at a latched base address.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   start             - begin a write-back (only honoured while idle)
//   size[1:0]         - matrix size: 0=2x2, 1=3x3, 2=4x4, 3=5x5
//   base_adrss[7:0]   - first word address of the result
//   result_valid      - result element available on result_data
//   result_data[7:0]  - result element
//   result_ready      - block accepts result_data this cycle
//   mem_adrss[7:0]    - memory write address (0 when not writing)
//   mem_data[15:0]    - memory write data (0 when not writing)
//   mem_wren          - one-cycle memory write strobe
//   busy              - high whenever not idle
//   done              - one-cycle pulse after the last word is written
module interface_out (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [7:0]  base_adrss,
  input  logic        result_valid,
  input  logic [7:0]  result_data,
  output logic        result_ready,
  output logic [7:0]  mem_adrss,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW = 5;
  localparam int unsigned IdxW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT_LO,
    S_COLLECT_HI,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [1:0]        size_q;
  logic [7:0]        base_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [7:0]        lo_q;
  logic [CntW-1:0]   n_elem;
  logic [CntW-1:0]   cnt_inc;

  // Element count of the latched matrix size.
  always_comb begin
    n_elem = CntW'(4);
    case (size_q)
      2'd0: n_elem = CntW'(4);
      2'd1: n_elem = CntW'(9);
      2'd2: n_elem = CntW'(16);
      2'd3: n_elem = CntW'(25);
      default: n_elem = CntW'(4);
    endcase
  end

  assign cnt_inc = CntW'(cnt_q + CntW'(1));

  // Transfer FSM; every output is updated alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      size_q       <= 2'd0;
      base_q       <= 8'd0;
      cnt_q        <= '0;
      idx_q        <= '0;
      lo_q         <= 8'd0;
      result_ready <= 1'b0;
      mem_adrss    <= 8'd0;
      mem_data     <= 16'd0;
      mem_wren     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Write and done strobes last exactly one cycle; bus is zero otherwise.
      mem_wren  <= 1'b0;
      mem_adrss <= 8'd0;
      mem_data  <= 16'd0;
      done      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            size_q       <= size;
            base_q       <= base_adrss;
            cnt_q        <= '0;
            idx_q        <= '0;
            result_ready <= 1'b1;
            busy         <= 1'b1;
            state_q      <= S_COLLECT_LO;
          end
        end
        S_COLLECT_LO: begin
          if (result_valid) begin
            lo_q  <= result_data;
            cnt_q <= cnt_inc;
            if (cnt_inc == n_elem) begin
              // Trailing element of an odd count: pad high byte with zero.
              result_ready <= 1'b0;
              mem_wren     <= 1'b1;
              mem_adrss    <= 8'(base_q + 8'(idx_q));
              mem_data     <= {8'h00, result_data};
              state_q      <= S_WRITE;
            end else begin
              state_q <= S_COLLECT_HI;
            end
          end
        end
        S_COLLECT_HI: begin
          if (result_valid) begin
            cnt_q        <= cnt_inc;
            result_ready <= 1'b0;
            mem_wren     <= 1'b1;
            mem_adrss    <= 8'(base_q + 8'(idx_q));
            mem_data     <= {result_data, lo_q};
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (cnt_q == n_elem) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q        <= IdxW'(idx_q + IdxW'(1));
            result_ready <= 1'b1;
            state_q      <= S_COLLECT_LO;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          result_ready <= 1'b0;
          busy         <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interface_out.sv
// Bench for interface_out: a transaction-level model predicts every output on
// every cycle; literal expectations pin the write sequences of each scenario.
module tb_interface_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  size;
  logic [7:0]  base_adrss;
  logic        result_valid;
  logic [7:0]  result_data;
  logic        result_ready;
  logic [7:0]  mem_adrss;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;

  interface_out dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .size         (size),
    .base_adrss   (base_adrss),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_ready (result_ready),
    .mem_adrss    (mem_adrss),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          armed = 0;
  bit          m_busy, m_ready, m_wr, m_done;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  int          m_n, m_k, m_widx;
  logic [7:0]  m_base;
  logic [7:0]  m_el[$];

  always @(posedge clk) begin
    bit pw, pd;
    cyc++;
    if (rst) begin
      armed = 1;
      m_busy = 0; m_ready = 0; m_wr = 0; m_done = 0;
      m_addr = 0; m_data = 0; m_n = 0; m_k = 0; m_widx = 0; m_base = 0;
      m_el.delete();
    end else begin
      pw = m_wr; pd = m_done;
      m_wr = 0; m_done = 0; m_addr = 0; m_data = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_ready = 1;
          m_n = (int'(size) + 2) * (int'(size) + 2);
          m_base = base_adrss; m_k = 0; m_widx = 0;
          m_el.delete();
        end
      end else if (pd) begin
        m_busy = 0;
      end else if (pw) begin
        if (m_k == m_n) m_done = 1;
        else begin
          m_widx++;
          m_ready = 1;
        end
      end else if (m_ready && result_valid) begin
        m_el.push_back(result_data);
        m_k++;
        if (m_k % 2 == 0 || m_k == m_n) begin
          m_wr = 1; m_ready = 0;
          m_addr = 8'(int'(m_base) + m_widx);
          m_data = (m_k % 2 == 0) ? {m_el[m_k-1], m_el[m_k-2]} : {8'h00, m_el[m_k-1]};
        end
      end
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  int          t0 = 0;
  logic [7:0]  log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          done_cnt, done_cyc, idle_cyc;
  bit          busy_prev = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("result_ready", int'(result_ready), int'(m_ready));
      check("busy",         int'(busy),         int'(m_busy));
      check("done",         int'(done),         int'(m_done));
      check("mem_wren",     int'(mem_wren),     int'(m_wr));
      check("mem_adrss",    int'(mem_adrss),    int'(m_addr));
      check("mem_data",     int'(mem_data),     int'(m_data));
      if (mem_wren) begin
        log_addr.push_back(mem_adrss);
        log_data.push_back(mem_data);
        log_cyc.push_back(cyc - t0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (busy_prev && !busy) idle_cyc = cyc - t0;
      busy_prev = busy;
    end
  end

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    done_cnt = 0; done_cyc = -1; idle_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Run one transfer of elements 1..N; optional gap before element 2, abort
  // (reset) right after element abort_after, spurious start at element restart_at.
  task automatic send(input logic [1:0] sz, input logic [7:0] base,
                      input int gap1, input int abort_after, input int restart_at);
    int  n;
    bit  acc, r;
    int  guard;
    n = (int'(sz) + 2) * (int'(sz) + 2);
    clear_log();
    start = 1; size = sz; base_adrss = base;
    t0 = cyc;
    step();
    start = 0;
    size = 2'(sz + 2'd1);
    base_adrss = 8'(base + 8'h55);
    for (int i = 1; i <= n; i++) begin
      if (i == 2 && gap1 > 0) begin
        result_valid = 0;
        repeat (gap1) step();
      end
      if (i == restart_at) begin
        start = 1; size = 2'd0; base_adrss = 8'h80;
      end
      result_valid = 1;
      result_data = 8'(i);
      acc = 0; guard = 0;
      while (!acc && guard < 60) begin
        @(negedge clk) r = result_ready;
        step();
        acc = r;
        guard++;
        start = 0;
      end
      if (!acc) begin
        check("accept_timeout", 0, 1);
        result_valid = 0;
        return;
      end
      if (i == abort_after) begin
        result_valid = 0;
        rst = 1;
        step();
        rst = 0;
        repeat (3) step();
        return;
      end
    end
    result_valid = 0;
    guard = 0;
    while (busy && guard < 40) begin
      step();
      guard++;
    end
    if (busy) check("idle_timeout", 0, 1);
    step();
  endtask

  initial begin
    rst = 1; start = 0; size = 0; base_adrss = 0; result_valid = 0; result_data = 0;
    repeat (2) step();
    check("rst_ready", int'(result_ready), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_wren",  int'(mem_wren), 0);
    check("rst_data",  int'(mem_data), 0);
    rst = 0;
    step();

    // 2x2, back-to-back data: exact cycle timing
    send(2'd0, 8'h10, 0, 0, 0);
    check("s1_nwr",   log_addr.size(), 2);
    check("s1_a0",    int'(log_addr[0]), 'h10);
    check("s1_d0",    int'(log_data[0]), 'h0201);
    check("s1_c0",    log_cyc[0], 3);
    check("s1_a1",    int'(log_addr[1]), 'h11);
    check("s1_d1",    int'(log_data[1]), 'h0403);
    check("s1_c1",    log_cyc[1], 6);
    check("s1_done",  done_cyc, 7);
    check("s1_idle",  idle_cyc, 8);

    // 3x3: odd trailing word padded with zero
    send(2'd1, 8'h20, 0, 0, 0);
    check("s2_nwr",   log_addr.size(), 5);
    check("s2_d2",    int'(log_data[2]), 'h0605);
    check("s2_alast", int'(log_addr[4]), 'h24);
    check("s2_dlast", int'(log_data[4]), 'h0009);
    check("s2_clast", log_cyc[4] - log_cyc[3], 2);
    check("s2_ndone", done_cnt, 1);

    // address wrap
    send(2'd1, 8'hFE, 0, 0, 0);
    check("s3_a0", int'(log_addr[0]), 'hFE);
    check("s3_a1", int'(log_addr[1]), 'hFF);
    check("s3_a2", int'(log_addr[2]), 'h00);
    check("s3_a4", int'(log_addr[4]), 'h02);

    // stall of 4 cycles between elements 1 and 2
    send(2'd0, 8'h10, 4, 0, 0);
    check("s4_d0", int'(log_data[0]), 'h0201);
    check("s4_c0", log_cyc[0], 7);
    check("s4_nwr", log_addr.size(), 2);

    // reset abort after 3 of 9 elements, then a clean 2x2 transfer
    send(2'd1, 8'h20, 0, 3, 0);
    check("s5_nwr",   log_addr.size(), 1);
    check("s5_ndone", done_cnt, 0);
    send(2'd0, 8'h40, 0, 0, 0);
    check("s5b_nwr",  log_addr.size(), 2);
    check("s5b_a1",   int'(log_addr[1]), 'h41);
    check("s5b_done", done_cnt, 1);

    // start re-asserted mid-transfer is ignored
    send(2'd1, 8'h30, 0, 0, 4);
    check("s6_nwr", log_addr.size(), 5);
    check("s6_a0",  int'(log_addr[0]), 'h30);
    check("s6_a4",  int'(log_addr[4]), 'h34);

    // 5x5
    send(2'd3, 8'h00, 0, 0, 0);
    check("s7_nwr",   log_addr.size(), 13);
    check("s7_a12",   int'(log_addr[12]), 'h0C);
    check("s7_d12",   int'(log_data[12]), 'h0019);
    check("s7_d11",   int'(log_data[11]), 'h1817);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interface_out.md
INTERFACE_OUT -- requirements
Module: interface_out

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin a result write-back, sampled only in IDLE.
REQ-004 SHALL have port size, input, 2 bits: matrix size, 00=2x2, 01=3x3, 10=4x4, 11=5x5.
REQ-005 SHALL have port base_adrss, input, 8 bits: first memory word address for the result.
REQ-006 SHALL have port result_valid, input, 1 bit: coprocessor result element valid.
REQ-007 SHALL have port result_data, input, 8 bits: result element, row-major order.
REQ-008 SHALL have port result_ready, output, 1 bit: block accepts result_data this cycle.
REQ-009 SHALL have port mem_adrss, output, 8 bits: memory write address.
REQ-010 SHALL have port mem_data, output, 16 bits: memory write data.
REQ-011 SHALL have port mem_wren, output, 1 bit: memory write enable.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when write-back completes.

Function
REQ-014 SHALL latch size and base_adrss when start=1 in IDLE; later changes SHALL NOT affect the transfer.
REQ-015 SHALL set element count N=(size+2)^2 (4, 9, 16, 25) and word count W=ceil(N/2) (2, 5, 8, 13).
REQ-016 SHALL implement the states IDLE, COLLECT_LO, COLLECT_HI, WRITE and DONE; all outputs SHALL be registered.
REQ-017 IDLE: result_ready=0; start=1 -> COLLECT_LO with element count=0 and word index=0.
REQ-018 COLLECT_LO: result_ready=1; on result_valid=1, SHALL store the low byte; if this is element N (odd N), SHALL set the high byte to 0x00 and go to WRITE, else go to COLLECT_HI.
REQ-019 COLLECT_HI: result_ready=1; on result_valid=1, SHALL store the high byte and go to WRITE.
REQ-020 A state SHALL hold while result_valid=0; no element SHALL be dropped or duplicated.
REQ-021 WRITE: mem_wren=1 for exactly one cycle, mem_adrss=base+word index (mod 256), mem_data={high byte, low byte}, result_ready=0.
REQ-022 After WRITE: if all N elements are written, go to DONE; else increment the word index and go to COLLECT_LO.
REQ-023 DONE: done=1 for one cycle, then return to IDLE.
REQ-024 mem_adrss and mem_data SHALL be 0 in every cycle where mem_wren=0.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 Address arithmetic SHALL wrap modulo 256 with no error indication.
REQ-027 With result_valid held high, each full word SHALL take 3 cycles (LO, HI, WRITE); a trailing odd word SHALL take 2 cycles.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge and set result_ready, mem_adrss, mem_data, mem_wren, busy and done to 0.
REQ-029 rst=1 SHALL clear the element count, word index, byte registers and latched size/base.
REQ-030 rst during any state SHALL abort the transfer: no further mem_wren pulse, partial word discarded, no done pulse.
REQ-031 rst SHALL take priority over start and result_valid in the same cycle.

Verification
REQ-032 size=00, base=0x10, start at cycle 0, result_valid high with data 01,02,03,04 -> writes 0x0201@0x10 (cycle 3), 0x0403@0x11 (cycle 6), done=1 at cycle 7, busy=0 at cycle 8.
REQ-033 size=01, base=0x20, data 01..09 -> 5 writes at 0x20..0x24, last mem_data=0x0009, exactly one done pulse.
REQ-034 size=01, base=0xFE -> write addresses FE, FF, 00, 01, 02.
REQ-035 size=00, result_valid low for 4 cycles between elements 1 and 2 -> result_ready stays 1, no mem_wren until element 2 is accepted, data still 0x0201.
REQ-036 rst pulse in COLLECT_HI after 3 of 9 elements -> no further mem_wren, no done; a following start with size=00 completes normally.
REQ-037 start re-asserted mid-transfer -> ignored: W write count and addresses unchanged.
